// File: rtl/qif_pkg.sv
// Shared definitions for the QIF spike-path blocks: default result widths,
// saturation limits and the result-holding state encoding.
package qif_pkg;

    localparam int RATE_W_DEF = 8;
    localparam int ISI_W_DEF  = 8;

    localparam logic [RATE_W_DEF-1:0] RATE_MAX_DEF = '1;
    localparam logic [ISI_W_DEF-1:0]  ISI_MAX_DEF  = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } qif_state_e;

endpackage

// File: rtl/qif_sat_counter.sv
// Up-counter with synchronous clear and hold; either sticks at all-ones
// (SATURATE=1) or wraps to zero (SATURATE=0).
module qif_sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic at_limit;

    assign at_limit = SATURATE && (q == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (!hold && inc && !at_limit) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/qif_spike_decoder.sv
// Decodes a single-bit spike train into a per-window spike count and the
// latest inter-spike interval, delivered over a valid/ready handshake.
module qif_spike_decoder
    import qif_pkg::*;
#(
    parameter int WINDOW = 64,
    parameter int RATE_W = RATE_W_DEF,
    parameter int ISI_W  = ISI_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spike_in,
    output logic [RATE_W-1:0] rate_out,
    output logic [ISI_W-1:0]  isi_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int                WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [RATE_W-1:0] RATE_MAX = '1;
    localparam logic [ISI_W-1:0]  ISI_MAX  = '1;

    logic              prev_p0;
    logic              have_prev;
    logic [ISI_W-1:0]  isi_reg;
    logic [WIN_W-1:0]  win_cnt;
    logic [RATE_W-1:0] spk_cnt;
    logic [ISI_W-1:0]  isi_tmr;
    logic              ev;
    logic              win_end;
    logic [RATE_W-1:0] rate_final;
    logic [ISI_W-1:0]  isi_meas;
    logic [ISI_W-1:0]  isi_final;
    qif_state_e        state;

    assign ev      = ena && spike_in && !prev_p0;
    assign win_end = ena && (win_cnt == WIN_LAST);

    // A window-end event still belongs to the closing window, so fold it in here.
    assign rate_final = (ev && spk_cnt != RATE_MAX) ? spk_cnt + 1'b1 : spk_cnt;
    assign isi_meas   = (isi_tmr == ISI_MAX) ? ISI_MAX : isi_tmr + 1'b1;
    assign isi_final  = (ev && have_prev) ? isi_meas : isi_reg;

    qif_sat_counter #(.WIDTH(WIN_W), .SATURATE(1'b0)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (1'b1),
        .clr  (win_end),
        .hold (!ena),
        .q    (win_cnt)
    );

    qif_sat_counter #(.WIDTH(RATE_W), .SATURATE(1'b1)) u_spk_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (ev),
        .clr  (win_end),
        .hold (!ena),
        .q    (spk_cnt)
    );

    qif_sat_counter #(.WIDTH(ISI_W), .SATURATE(1'b1)) u_isi_tmr (
        .clk  (clk),
        .rst  (rst),
        .inc  (1'b1),
        .clr  (ev),
        .hold (!ena),
        .q    (isi_tmr)
    );

    // Edge-detect sample keeps tracking the input even while decoding is paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p0   <= 1'b0;
            have_prev <= 1'b0;
            isi_reg   <= '0;
        end else begin
            prev_p0 <= spike_in;
            if (ev) begin
                have_prev <= 1'b1;
                isi_reg   <= isi_final;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rate_out <= '0;
            isi_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (win_end) begin
                        state    <= FULL;
                        rate_out <= rate_final;
                        isi_out  <= isi_final;
                    end
                end
                FULL: begin
                    if (win_end && out_ready) begin
                        rate_out <= rate_final;
                        isi_out  <= isi_final;
                    end else if (win_end) begin
                        overflow <= 1'b1;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state == FULL);

endmodule
